// File: rtl/matrix_alu_seq_if.sv
// rtl/matrix_alu_seq_if.sv - execute-stage bus bundle for the sequential matrix ALU
interface matrix_alu_seq_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [15:0]      address;
  logic [N*N*W-1:0] ExeDataOut;
  logic             nWrite;
  logic             nRead;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic [N*N*W-1:0] MatrixDataOut;

  modport master (
    output address, ExeDataOut, nWrite, nRead, Start,
    input  Busy, Done, Err, MatrixDataOut
  );

  modport slave (
    input  address, ExeDataOut, nWrite, nRead, Start,
    output Busy, Done, Err, MatrixDataOut
  );
endinterface

// File: rtl/matrix_alu_seq.sv
// rtl/matrix_alu_seq.sv - multi-cycle NxN matrix ALU, one result element per clock
module matrix_alu_seq #(
  parameter int         N         = 4,
  parameter int         W         = 16,
  parameter logic [3:0] ENABLE_ID = 4'd3,
  parameter bit         SAT       = 1'b0
) (
  input logic Clk,
  input logic nReset,
  matrix_alu_seq_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int BW = N*N*W;
  localparam int AW = 2*W + $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_a, r_b, r_sa, r_sb, r_r, r_out;
  logic [W-1:0]    r_imm;
  logic [7:0]      r_op;
  logic [IW-1:0]   r_i, r_j;
  logic            r_busy, r_done, r_err;

  logic            w_en;
  logic [3:0]      w_sel;
  logic [7:0]      w_opc;
  logic            w_supported;
  logic [W-1:0]    w_ea, w_eb, w_elem;
  logic [AW-1:0]   w_acc;

  function automatic logic [W-1:0] el(input logic [BW-1:0] m, input int ii, input int jj);
    return m[(N*N-1-(ii*N+jj))*W +: W];
  endfunction

  function automatic logic [W-1:0] reduce(input logic [AW-1:0] v);
    if (SAT && (|v[AW-1:W])) return '1;
    return v[W-1:0];
  endfunction

  assign w_en        = (bus.address[15:12] == ENABLE_ID);
  assign w_sel       = bus.address[11:8];
  assign w_opc       = bus.address[7:0];
  assign w_supported = (w_opc <= 8'h05);
  assign w_ea        = el(r_sa, int'(r_i), int'(r_j));
  assign w_eb        = el(r_sb, int'(r_i), int'(r_j));

  // Operands come from the snapshot taken at Start, so a same-edge write cannot leak in
  always_comb begin
    w_acc  = '0;
    w_elem = '0;
    case (r_op)
      8'h00: begin
        for (int k = 0; k < N; k++)
          w_acc = w_acc + AW'(el(r_sa, int'(r_i), k)) * AW'(el(r_sb, k, int'(r_j)));
        w_elem = reduce(w_acc);
      end
      8'h01: begin
        w_acc  = AW'(w_ea) + AW'(w_eb);
        w_elem = reduce(w_acc);
      end
      8'h02:   w_elem = (SAT && (w_ea < w_eb)) ? '0 : w_ea - w_eb;
      8'h03:   w_elem = el(r_sa, int'(r_j), int'(r_i));
      8'h04: begin
        w_acc  = AW'(w_ea) * AW'(el(r_sb, N-1, N-1));
        w_elem = reduce(w_acc);
      end
      8'h05: begin
        w_acc  = AW'(w_ea) * AW'(r_imm);
        w_elem = reduce(w_acc);
      end
      default: w_elem = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_r     <= '0;
      r_out   <= '0;
      r_imm   <= '0;
      r_op    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_en && !bus.nWrite && r_state == IDLE) begin
        if (w_sel == 4'd0)      r_a <= bus.ExeDataOut;
        else if (w_sel == 4'd1) r_b <= bus.ExeDataOut;
      end
      if (w_en && !bus.nRead && r_state != BUSY)
        r_out <= r_r;

      case (r_state)
        IDLE: begin
          if (w_en && bus.Start) begin
            r_op  <= w_opc;
            r_imm <= bus.ExeDataOut[W-1:0];
            r_sa  <= r_a;
            r_sb  <= r_b;
            r_i   <= '0;
            r_j   <= '0;
            if (w_supported) begin
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= BUSY;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        BUSY: begin
          r_r[(N*N-1-(int'(r_i)*N+int'(r_j)))*W +: W] <= w_elem;
          if (r_j == IW'(N-1)) begin
            r_j <= '0;
            if (r_i == IW'(N-1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy          = r_busy;
  assign bus.Done          = r_done;
  assign bus.Err           = r_err;
  assign bus.MatrixDataOut = r_out;
endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb/tb_matrix_alu_seq.sv - bench for matrix_alu_seq, wrap and saturating instances side by side
module tb_matrix_alu_seq;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BW = N*N*W;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  matrix_alu_seq_if #(.N(N), .W(W)) b0 ();
  matrix_alu_seq_if #(.N(N), .W(W)) b1 ();

  matrix_alu_seq #(.N(N), .W(W), .ENABLE_ID(4'd3), .SAT(1'b0)) dut0 (.Clk(Clk), .nReset(nReset), .bus(b0));
  matrix_alu_seq #(.N(N), .W(W), .ENABLE_ID(4'd3), .SAT(1'b1)) dut1 (.Clk(Clk), .nReset(nReset), .bus(b1));

  int n_assert = 0;
  int n_fail   = 0;
  logic [BW-1:0] ma, mb;
  logic [BW-1:0] er [2];
  logic [BW-1:0] eo [2];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] addr, input logic [BW-1:0] d, input logic nw, input logic nr, input logic st);
    b0.address = addr; b0.ExeDataOut = d; b0.nWrite = nw; b0.nRead = nr; b0.Start = st;
    b1.address = addr; b1.ExeDataOut = d; b1.nWrite = nw; b1.nRead = nr; b1.Start = st;
  endtask

  task automatic idle_bus();
    drive(16'h0000, '0, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] m, input int i, input int j, input logic [W-1:0] v);
    logic [BW-1:0] r;
    r = m;
    r[(N*N-1-(i*N+j))*W +: W] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_mat();
    logic [BW-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*W +: W] = 16'($urandom);
    return m;
  endfunction

  // Reference: unpack into 2-D integer arrays, do plain arithmetic, repack
  function automatic logic [BW-1:0] model(input logic [7:0] op, input bit sat, input logic [BW-1:0] a,
                                          input logic [BW-1:0] b, input longint unsigned imm, input logic [BW-1:0] r_old);
    longint unsigned x [N][N];
    longint unsigned y [N][N];
    longint unsigned v, maxv;
    logic [BW-1:0] res, tmp;
    maxv = (64'd1 << W) - 1;
    if (op > 8'h05) return r_old;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tmp = a >> ((N*N-1-(i*N+j))*W); x[i][j] = 64'(tmp[W-1:0]);
        tmp = b >> ((N*N-1-(i*N+j))*W); y[i][j] = 64'(tmp[W-1:0]);
      end
    res = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        v = 0;
        case (op)
          8'h00: for (int k = 0; k < N; k++) v += x[i][k] * y[k][j];
          8'h01: v = x[i][j] + y[i][j];
          8'h02: v = (x[i][j] >= y[i][j]) ? x[i][j] - y[i][j] : (sat ? 0 : x[i][j] + maxv + 1 - y[i][j]);
          8'h03: v = x[j][i];
          8'h04: v = x[i][j] * y[N-1][N-1];
          default: v = x[i][j] * imm;
        endcase
        if (sat && v > maxv) v = maxv;
        v &= maxv;
        res = put(res, i, j, v[W-1:0]);
      end
    return res;
  endfunction

  task automatic wr(input logic [3:0] sel, input logic [BW-1:0] d);
    drive({4'd3, sel, 8'h00}, d, 1'b0, 1'b1, 1'b0);
    tick();
    idle_bus();
    if (sel == 4'd0) ma = d; else mb = d;
  endtask

  task automatic do_read(input string tag);
    drive({4'd3, 4'd0, 8'h00}, '0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_bus();
    for (int s = 0; s < 2; s++) eo[s] = er[s];
    check({tag, "_out0"}, b0.MatrixDataOut, eo[0]);
    check({tag, "_out1"}, b1.MatrixDataOut, eo[1]);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy0"}, BW'(b0.Busy), '0);
    check({tag, "_busy1"}, BW'(b1.Busy), '0);
    check({tag, "_done0"}, BW'(b0.Done), '0);
    check({tag, "_err0"},  BW'(b0.Err),  '0);
    check({tag, "_out0"},  b0.MatrixDataOut, '0);
    check({tag, "_out1"},  b1.MatrixDataOut, '0);
  endtask

  task automatic model_reset();
    ma = '0; mb = '0;
    for (int s = 0; s < 2; s++) begin er[s] = '0; eo[s] = '0; end
  endtask

  task automatic run(input string tag, input logic [7:0] op, input logic [BW-1:0] d,
                     input bit mid_read, input bit do_wr, input logic [3:0] wsel);
    logic [BW-1:0] exp [2];
    int cnt0, cnt1;
    bit bad;
    bad = (op > 8'h05);
    for (int s = 0; s < 2; s++) exp[s] = model(op, s[0], ma, mb, 64'(d[W-1:0]), er[s]);
    drive({4'd3, do_wr ? wsel : 4'hF, op}, d, !do_wr, 1'b1, 1'b1);
    tick();
    idle_bus();
    if (do_wr && wsel == 4'd0) ma = d;
    if (do_wr && wsel == 4'd1) mb = d;
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 100 && (b0.Busy || b1.Busy); c++) begin
      if (b0.Busy) cnt0++;
      if (b1.Busy) cnt1++;
      if (mid_read && c == 3) drive({4'd3, 4'd0, 8'h00}, '0, 1'b1, 1'b0, 1'b0);
      tick();
      idle_bus();
      if (mid_read && c == 3) begin
        check({tag, "_midrd0"}, b0.MatrixDataOut, eo[0]);
        check({tag, "_midrd1"}, b1.MatrixDataOut, eo[1]);
      end
    end
    check({tag, "_busycnt0"}, BW'(cnt0), bad ? BW'(0) : BW'(N*N));
    check({tag, "_busycnt1"}, BW'(cnt1), bad ? BW'(0) : BW'(N*N));
    check({tag, "_done0"}, BW'(b0.Done), BW'(1));
    check({tag, "_done1"}, BW'(b1.Done), BW'(1));
    check({tag, "_err0"},  BW'(b0.Err),  BW'(bad));
    check({tag, "_err1"},  BW'(b1.Err),  BW'(bad));
    tick();
    check({tag, "_donelow0"}, BW'(b0.Done), '0);
    for (int s = 0; s < 2; s++) er[s] = exp[s];
    do_read(tag);
  endtask

  initial begin
    logic [BW-1:0] m, m2;
    idle_bus();
    model_reset();
    tick();
    tick();
    nReset = 1'b1;
    check_idle_zero("por");

    wr(4'd0, rand_mat());
    wr(4'd1, rand_mat());
    run("pre_rst", 8'h01, '0, 1'b0, 1'b0, 4'd0);
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    model_reset();
    check_idle_zero("rst");
    do_read("rst_rd");

    m = '0; m2 = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m  = put(m, i, j, (i == j) ? 16'd1 : 16'd0);
        m2 = put(m2, i, j, 16'(i*4+j));
      end
    wr(4'd0, m);
    wr(4'd1, m2);
    run("mmult_id", 8'h00, '0, 1'b0, 1'b0, 4'd0);
    check("mmult_id_isb", b0.MatrixDataOut, m2);

    wr(4'd0, {N*N{16'hFFFF}});
    wr(4'd1, {N*N{16'h0002}});
    run("madd_ovf", 8'h01, '0, 1'b0, 1'b0, 4'd0);
    check("madd_wrap_const", b0.MatrixDataOut, {N*N{16'h0001}});
    check("madd_sat_const",  b1.MatrixDataOut, {N*N{16'hFFFF}});

    wr(4'd0, {N*N{16'h0001}});
    run("msub_neg", 8'h02, '0, 1'b0, 1'b0, 4'd0);
    check("msub_sat_const", b1.MatrixDataOut, '0);

    wr(4'd0, m2);
    run("scaleimm", 8'h05, BW'(16'd3), 1'b1, 1'b0, 4'd0);

    run("badop", 8'h07, '0, 1'b0, 1'b0, 4'd0);
    run("scale_after_err", 8'h04, '0, 1'b0, 1'b0, 4'd0);

    run("wr_and_start", 8'h01, rand_mat(), 1'b0, 1'b1, 4'd0);
    run("after_simul", 8'h01, '0, 1'b0, 1'b0, 4'd0);

    for (int t = 0; t < 8; t++) begin
      wr(4'd0, rand_mat());
      wr(4'd1, rand_mat());
      run($sformatf("rnd%0d", t), 8'($urandom_range(0, 6)), rand_mat(), 1'b0, 1'b0, 4'd0);
    end

    wr(4'd0, rand_mat());
    drive({4'd3, 4'hF, 8'h03}, '0, 1'b1, 1'b1, 1'b1);
    tick();
    idle_bus();
    for (int c = 0; c < 4; c++) tick();
    check("abort_busy", BW'(b0.Busy), BW'(1));
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    model_reset();
    check_idle_zero("abort");
    do_read("abort_rd");

    drive({4'd2, 4'd0, 8'h01}, rand_mat(), 1'b0, 1'b0, 1'b1);
    tick();
    idle_bus();
    check("dis_busy0", BW'(b0.Busy), '0);
    check("dis_done0", BW'(b0.Done), '0);
    check("dis_out0",  b0.MatrixDataOut, '0);
    run("dis_after", 8'h01, '0, 1'b0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
